// File: rtl/lock_pkg.sv
// Shared constants and types for the digital lock: the button front end and the
// lock FSM agree on key width and encoding through this package.
package lock_pkg;
  localparam int N_BTN                   = 4;
  localparam int KEY_W                   = 2;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;

  typedef logic [KEY_W-1:0] key_t;
endpackage : lock_pkg

// File: rtl/debounce_cell.sv
// One button bit: two-flop synchroniser, hold counter and accepted (stable) level.
// A new level is accepted only after it has been seen DEBOUNCE_CYCLES times in a row.
module debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable
);
  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;
endmodule : debounce_cell

// File: rtl/button_conditioner.sv
// Lock input front end: debounces every button and turns clean presses into
// single-cycle key events, flagging chords as errors.
module button_conditioner
  import lock_pkg::key_t;
#(
  parameter int N_BTN           = lock_pkg::N_BTN,
  parameter int DEBOUNCE_CYCLES = lock_pkg::DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] button,
  output logic [N_BTN-1:0] btn_level,
  output logic             key_valid,
  output key_t             key_code,
  output logic             key_error
);
  logic [N_BTN-1:0] stable;
  logic [N_BTN-1:0] stable_d_q;
  logic [N_BTN-1:0] rise;
  logic             key_valid_q, key_valid_d;
  logic             key_error_q, key_error_d;
  key_t             key_code_q, key_code_d;
  int               rise_cnt;
  key_t             rise_idx;

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_btn
      debounce_cell #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_cell (
        .clk    (clk),
        .rst    (rst),
        .raw    (button[gi]),
        .stable (stable[gi])
      );
    end
  endgenerate

  assign rise = stable & ~stable_d_q;

  always_comb begin
    rise_cnt    = 0;
    rise_idx    = '0;
    key_valid_d = 1'b0;
    key_error_d = 1'b0;
    key_code_d  = key_code_q;
    for (int i = 0; i < N_BTN; i++) begin
      if (rise[i]) begin
        rise_cnt = rise_cnt + 1;
        rise_idx = key_t'(i);
      end
    end
    // A press is only legal when nothing else was already held.
    if (rise_cnt == 1 && stable_d_q == '0) begin
      key_valid_d = 1'b1;
      key_code_d  = rise_idx;
    end else if (rise_cnt != 0) begin
      key_error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_d_q  <= '0;
      key_valid_q <= 1'b0;
      key_error_q <= 1'b0;
      key_code_q  <= '0;
    end else begin
      stable_d_q  <= stable;
      key_valid_q <= key_valid_d;
      key_error_q <= key_error_d;
      key_code_q  <= key_code_d;
    end
  end

  assign btn_level = stable;
  assign key_valid = key_valid_q;
  assign key_error = key_error_q;
  assign key_code  = key_code_q;
endmodule : button_conditioner

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4: a cycle-by-cycle
// vector table plus hand-written asynchronous reset sequences.
module tb_button_conditioner;
  logic       clk;
  logic       rst;
  logic [3:0] button;
  logic [3:0] btn_level;
  logic       key_valid;
  logic [1:0] key_code;
  logic       key_error;

  int checks = 0;
  int errors = 0;

  button_conditioner #(
    .N_BTN           (4),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .button    (button),
    .btn_level (btn_level),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_error (key_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] btn;
    int         reps;
    logic [3:0] lvl;
    logic       kv;
    logic [1:0] kc;
    logic       ke;
    string      nm;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] b, input int n, input logic [3:0] l,
                              input logic kv, input logic [1:0] kc, input logic ke,
                              input string nm);
    vec_t v;
    v.btn = b; v.reps = n; v.lvl = l; v.kv = kv; v.kc = kc; v.ke = ke; v.nm = nm;
    return v;
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input string nm, input logic [3:0] l, input logic kv,
                           input logic [1:0] kc, input logic ke);
    check({nm, ".btn_level"}, {4'b0, btn_level}, {4'b0, l});
    check({nm, ".key_valid"}, {7'b0, key_valid}, {7'b0, kv});
    check({nm, ".key_code"},  {6'b0, key_code},  {6'b0, kc});
    check({nm, ".key_error"}, {7'b0, key_error}, {7'b0, ke});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Clean press of button 2, held then released: one valid, code 2.
    vecs.push_back(mk(4'b0100, 5,  4'b0000, 0, 2'd0, 0, "press_wait"));
    vecs.push_back(mk(4'b0100, 1,  4'b0100, 0, 2'd0, 0, "press_level"));
    vecs.push_back(mk(4'b0100, 1,  4'b0100, 1, 2'd2, 0, "press_valid"));
    vecs.push_back(mk(4'b0100, 13, 4'b0100, 0, 2'd2, 0, "press_hold"));
    vecs.push_back(mk(4'b0000, 5,  4'b0100, 0, 2'd2, 0, "release_wait"));
    vecs.push_back(mk(4'b0000, 3,  4'b0000, 0, 2'd2, 0, "release_done"));
    // 3-cycle glitch on button 3 is rejected.
    vecs.push_back(mk(4'b1000, 3,  4'b0000, 0, 2'd2, 0, "glitch_on"));
    vecs.push_back(mk(4'b0000, 8,  4'b0000, 0, 2'd2, 0, "glitch_off"));
    // Buttons 1 and 3 together: error, code stays 2.
    vecs.push_back(mk(4'b1010, 5,  4'b0000, 0, 2'd2, 0, "chord_wait"));
    vecs.push_back(mk(4'b1010, 1,  4'b1010, 0, 2'd2, 0, "chord_level"));
    vecs.push_back(mk(4'b1010, 1,  4'b1010, 0, 2'd2, 1, "chord_error"));
    vecs.push_back(mk(4'b1010, 3,  4'b1010, 0, 2'd2, 0, "chord_hold"));
    vecs.push_back(mk(4'b0000, 5,  4'b1010, 0, 2'd2, 0, "chord_rel"));
    vecs.push_back(mk(4'b0000, 3,  4'b0000, 0, 2'd2, 0, "chord_idle"));
    // Bounce on button 0: 1,0,1,1,0 then steady 1.
    vecs.push_back(mk(4'b0001, 1,  4'b0000, 0, 2'd2, 0, "bounce_a"));
    vecs.push_back(mk(4'b0000, 1,  4'b0000, 0, 2'd2, 0, "bounce_b"));
    vecs.push_back(mk(4'b0001, 2,  4'b0000, 0, 2'd2, 0, "bounce_c"));
    vecs.push_back(mk(4'b0000, 1,  4'b0000, 0, 2'd2, 0, "bounce_d"));
    vecs.push_back(mk(4'b0001, 5,  4'b0000, 0, 2'd2, 0, "bounce_wait"));
    vecs.push_back(mk(4'b0001, 1,  4'b0001, 0, 2'd2, 0, "bounce_level"));
    vecs.push_back(mk(4'b0001, 1,  4'b0001, 1, 2'd0, 0, "bounce_valid"));
    vecs.push_back(mk(4'b0001, 5,  4'b0001, 0, 2'd0, 0, "bounce_hold"));
    vecs.push_back(mk(4'b0000, 5,  4'b0001, 0, 2'd0, 0, "bounce_rel"));
    vecs.push_back(mk(4'b0000, 3,  4'b0000, 0, 2'd0, 0, "bounce_idle"));
    // Button 1 held, then button 3 added: valid code 1, then error.
    vecs.push_back(mk(4'b0010, 5,  4'b0000, 0, 2'd0, 0, "seq_wait"));
    vecs.push_back(mk(4'b0010, 1,  4'b0010, 0, 2'd0, 0, "seq_level"));
    vecs.push_back(mk(4'b0010, 1,  4'b0010, 1, 2'd1, 0, "seq_valid"));
    vecs.push_back(mk(4'b0010, 2,  4'b0010, 0, 2'd1, 0, "seq_hold"));
    vecs.push_back(mk(4'b1010, 5,  4'b0010, 0, 2'd1, 0, "seq_add_wait"));
    vecs.push_back(mk(4'b1010, 1,  4'b1010, 0, 2'd1, 0, "seq_add_level"));
    vecs.push_back(mk(4'b1010, 1,  4'b1010, 0, 2'd1, 1, "seq_error"));
    vecs.push_back(mk(4'b1010, 3,  4'b1010, 0, 2'd1, 0, "seq_hold2"));
    vecs.push_back(mk(4'b0000, 5,  4'b1010, 0, 2'd1, 0, "seq_rel"));
    vecs.push_back(mk(4'b0000, 3,  4'b0000, 0, 2'd1, 0, "seq_idle"));

    rst    = 1'b1;
    button = 4'b0000;
    repeat (3) step();
    check_all("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
    @(posedge clk);
    #4 rst = 1'b0;

    for (int v = 0; v < vecs.size(); v++) begin
      button = vecs[v].btn;
      for (int r = 0; r < vecs[v].reps; r++) begin
        step();
        $display("vec %0d %s rep %0d btn=%b lvl=%b kv=%b kc=%0d ke=%b", v, vecs[v].nm, r,
                 button, btn_level, key_valid, key_code, key_error);
        check_all(vecs[v].nm, vecs[v].lvl, vecs[v].kv, vecs[v].kc, vecs[v].ke);
      end
    end

    // Reset mid-count: press button 2, assert rst while its counter is at 2.
    button = 4'b0100;
    repeat (4) step();
    #1 rst = 1'b1;
    #1 check_all("rst_midcount", 4'b0000, 1'b0, 2'd0, 1'b0);
    $display("reset mid-count lvl=%b kv=%b kc=%0d ke=%b", btn_level, key_valid, key_code, key_error);
    step();
    @(posedge clk);
    #3 rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      step();
      $display("after reset edge %0d lvl=%b kv=%b kc=%0d", e, btn_level, key_valid, key_code);
      check_all("rst_repress", (e >= 6) ? 4'b0100 : 4'b0000, (e == 7),
                (e == 7) ? 2'd2 : 2'd0, 1'b0);
    end

    // Reset while key_valid is high: pulse is dropped immediately.
    #1 rst = 1'b1;
    #1 check_all("rst_midpulse", 4'b0000, 1'b0, 2'd0, 1'b0);
    $display("reset mid-pulse lvl=%b kv=%b kc=%0d ke=%b", btn_level, key_valid, key_code, key_error);
    step();
    @(posedge clk);
    #3 rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      $display("held through reset edge %0d lvl=%b kv=%b kc=%0d", e, btn_level, key_valid, key_code);
      check_all("rst_held", (e >= 6) ? 4'b0100 : 4'b0000, (e == 7),
                (e >= 7) ? 2'd2 : 2'd0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule : tb_button_conditioner
